// File: rtl/gate_envelope_ctrl.sv
// Noise gate envelope controller: hysteresis FSM (closed/attack/open/hold/release)
// producing a 0..256 gain that is applied to the sample stream with one cycle latency.
module gate_envelope_ctrl #(
  parameter int unsigned HOLD_SAMPLES = 480,
  parameter int unsigned RAMP_STEP    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [2:0]         i_level,
  input  logic signed [15:0] i_data,
  output logic signed [15:0] o_data,
  output logic               o_valid,
  output logic [2:0]         o_state,
  output logic [8:0]         o_gain
);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } state_e;

  localparam int unsigned CW        = $clog2(HOLD_SAMPLES + 1);
  localparam logic [9:0]  STEP      = 10'(RAMP_STEP);
  localparam logic [9:0]  UNITY     = 10'd256;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_SAMPLES);

  state_e              state_q, state_d;
  logic [8:0]          gain_q, gain_d;
  logic [CW-1:0]       hold_q, hold_d;
  logic signed [15:0]  data_q, data_d;
  logic                valid_q, valid_d;

  logic [14:0]         t_open;
  logic [14:0]         t_close;
  logic [15:0]         mag;
  logic                loud_open, loud_close;
  logic [9:0]          gain_sum;
  logic [8:0]          gain_up, gain_dn, gain_first;
  logic signed [24:0]  prod;

  always_comb begin
    case (i_level)
      3'd0:    t_open = 15'd0;
      3'd1:    t_open = 15'd300;
      3'd2:    t_open = 15'd600;
      3'd3:    t_open = 15'd1200;
      3'd4:    t_open = 15'd2400;
      3'd5:    t_open = 15'd4000;
      3'd6:    t_open = 15'd8000;
      default: t_open = 15'd15000;
    endcase
    t_close = t_open >> 1;

    // -32768 has no positive twin in 16 bits, so it clamps to 32767
    if (i_data == 16'sh8000)  mag = 16'h7fff;
    else if (i_data[15])      mag = 16'(-i_data);
    else                      mag = i_data;
    loud_open  = (mag >= {1'b0, t_open});
    loud_close = (mag >= {1'b0, t_close});

    gain_sum   = {1'b0, gain_q} + STEP;
    gain_up    = (gain_sum >= UNITY) ? 9'd256 : gain_sum[8:0];
    gain_dn    = ({1'b0, gain_q} > STEP) ? 9'({1'b0, gain_q} - STEP) : 9'd0;
    gain_first = (STEP >= UNITY) ? 9'd256 : STEP[8:0];
  end

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = i_valid;
    prod    = '0;

    if (i_valid) begin
      if (!i_enable) begin
        state_d = OPEN;
        gain_d  = 9'd256;
        hold_d  = '0;
      end else begin
        case (state_q)
          CLOSED: begin
            if (loud_open) begin
              gain_d  = gain_first;
              state_d = (gain_first == 9'd256) ? OPEN : ATTACK;
            end
          end
          ATTACK: begin
            gain_d  = gain_up;
            state_d = (gain_up == 9'd256) ? OPEN : ATTACK;
          end
          OPEN: begin
            gain_d = 9'd256;
            if (!loud_close) begin
              hold_d  = CW'(1);
              state_d = (HOLD_SAMPLES == 1) ? RELEASE : HOLD;
            end
          end
          HOLD: begin
            gain_d = 9'd256;
            if (loud_close) begin
              hold_d  = '0;
              state_d = OPEN;
            end else begin
              hold_d = hold_q + CW'(1);
              if (hold_d == HOLD_LAST) state_d = RELEASE;
            end
          end
          RELEASE: begin
            if (loud_open) begin
              gain_d  = gain_up;
              state_d = (gain_up == 9'd256) ? OPEN : ATTACK;
            end else begin
              gain_d  = gain_dn;
              state_d = (gain_dn == 9'd0) ? CLOSED : RELEASE;
            end
          end
          default: begin
            gain_d  = '0;
            hold_d  = '0;
            state_d = CLOSED;
          end
        endcase
      end
      // Gain is applied to the same sample that produced it
      prod   = i_data * $signed({1'b0, gain_d});
      data_d = 16'(prod >>> 8);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= CLOSED;
      gain_q  <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_state = state_q;
  assign o_gain  = gain_q;

endmodule

// File: doc/gate_envelope_ctrl.md
# gate_envelope_ctrl

Sample-rate controller for the noise gate stage of the effect chain. It replaces a hard per-sample mute with a hysteresis state machine that has attack, hold and release phases. It produces a 0..256 gain envelope and applies that gain to the sample stream. It sits in the same chain slot as the gate effect and uses the same valid-strobe handshake, `i_enable` bypass and 3-bit `i_level` control.

## Interface

Parameters:
- `HOLD_SAMPLES`, default 480: number of consecutive quiet valid samples required before release starts (10 ms at 48 kHz). Range ≥1.
- `RAMP_STEP`, default 16: gain change per valid sample during attack and release. Range 1..256.

Ports:
- `i_clk`, in, 1: single clock.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_valid`, in, 1: sample strobe, one cycle per sample.
- `i_enable`, in, 1: 1 = gate active, 0 = bypass.
- `i_level`, in, 3: threshold select.
- `i_data`, in, 16 signed: input sample.
- `o_data`, out, 16 signed: gained sample, registered.
- `o_valid`, out, 1: output strobe.
- `o_state`, out, 3: current state (CLOSED=0, ATTACK=1, OPEN=2, HOLD=3, RELEASE=4).
- `o_gain`, out, 9: current gain, 0..256, where 256 = unity.

## Operation

Threshold table:
- `T_open` by `i_level` 0..7 is 0, 300, 600, 1200, 2400, 4000, 8000, 15000.
- `T_close` = `T_open` >> 1.
- Level 0 gives `T_open` = 0, so the gate is always open once attack completes.
- Level changes take effect at the next valid sample. Changing level never resets the state.

Magnitude:
- `abs` = |`i_data`|.
- An input of -32768 saturates to 32767.

State, gain and hold counter update only on cycles where `i_valid`=1. On other cycles all state is frozen.

Per valid sample, with `i_enable`=1:
- **CLOSED:**
  - If `abs` ≥ `T_open`: gain = min(`RAMP_STEP`, 256), go to ATTACK. If that gain is 256, go to OPEN instead.
  - Otherwise gain stays 0.
- **ATTACK:**
  - gain = min(gain + `RAMP_STEP`, 256).
  - If the new gain is 256, go to OPEN.
  - Input level is ignored in this state.
- **OPEN:**
  - gain = 256.
  - If `abs` < `T_close`: hold_cnt = 1, go to HOLD.
  - If `HOLD_SAMPLES` = 1, go straight to RELEASE instead.
- **HOLD:**
  - gain stays 256.
  - If `abs` ≥ `T_close`: go to OPEN and clear hold_cnt.
  - Otherwise hold_cnt increments. When hold_cnt reaches `HOLD_SAMPLES`, go to RELEASE. The gain on that sample is still 256.
- **RELEASE:**
  - If `abs` ≥ `T_open`: gain = min(gain + `RAMP_STEP`, 256), go to ATTACK (or OPEN if gain is now 256).
  - Otherwise gain = max(gain − `RAMP_STEP`, 0). If the new gain is 0, go to CLOSED.

Bypass, with `i_enable`=0 on a valid sample:
- State is forced to OPEN, gain to 256 and hold_cnt to 0.
- `o_data` = `i_data`.

Datapath:
- `o_data` = (`i_data` × gain) >>> 8, using the gain computed for that same sample.
- Multiply is signed 16 × unsigned 9, with a 25-bit intermediate and arithmetic shift.
- Because gain ≤ 256, the result always fits 16 bits and no saturation is needed.
- Gain 256 reproduces `i_data` exactly.

## Timing

- Latency is 1 cycle. `o_valid` is `i_valid` registered; `o_data` updates on the same edge.
- Between valid strobes, `o_data`, `o_gain` and `o_state` hold their values.
- `o_state` and `o_gain` are registered and reflect the post-update values of the last valid sample.
- Back-to-back valid cycles are supported at one sample per clock.
- Reset, asserted at any time including mid-ramp, immediately sets: `o_data`=0, `o_valid`=0, `o_state`=CLOSED, `o_gain`=0, hold_cnt=0.
- The first valid sample after reset is evaluated from CLOSED.

## Test plan

All scenarios use `HOLD_SAMPLES`=4 and `RAMP_STEP`=64 unless stated.

1. **Attack ramp:**
   - Stimulus: level 3, CLOSED, five valid samples of 2000.
   - Required gains: 64, 128, 192, 256, 256.
   - Required `o_data`: 500, 1000, 1500, 2000, 2000.
   - Required states: ATTACK ×3, then OPEN, OPEN.
2. **Hysteresis and hold:**
   - Stimulus: from OPEN at level 3, send 800, then 500 ×3, then 700, then 500 ×4, then 500.
   - 800 → stays OPEN.
   - 500 ×3 → HOLD.
   - 700 → OPEN.
   - 500 ×4 → HOLD, HOLD, HOLD, then RELEASE with gain 256.
   - Final 500 → gain 192, `o_data` 375.
3. **Release, close and retrigger:**
   - Stimulus: in RELEASE at gain 192, send 0 ×3, then 1300.
   - 0 ×3 → gains 128, 64, 0; state CLOSED on the third sample.
   - 1300 → ATTACK, gain 64, `o_data` 325.
4. **Bypass and edge magnitude:**
   - With `i_enable`=0, level 7, sample −100: `o_data` = −100 one cycle later, state OPEN, gain 256.
   - With `i_enable`=1, CLOSED, level 7, sample −32768: ATTACK, `o_data` = −8192.
5. **Strobe gaps:**
   - Stimulus: `i_valid` low for 10 cycles mid-attack.
   - Required: `o_valid`=0 throughout; `o_data`, gain, state and hold_cnt unchanged.
   - On the next valid sample, the ramp resumes from the frozen gain.
6. **Asynchronous reset:**
   - Stimulus: assert `i_rst` between clock edges while in RELEASE.
   - Required: all outputs go to reset values without waiting for a clock edge.
   - After release, a 2000 sample at level 3 gives gain 64.
